// File: rtl/sample_buffer_pkg.sv
// Shared types and width helpers for the sample buffer and its storage.
package sample_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } stream_state_e;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_buffer_ram.sv
// Sample storage: one write port, a registered read-first read port and an
// asynchronous peek port used by the streaming engine to snapshot entries.
module sample_buffer_ram
  import sample_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic [ADDR_W-1:0] peek_addr_i,
  output logic [DATA_W-1:0] peek_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Contents survive reset; only the bitmap in the top level says what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o   = rd_data_q;
  assign peek_data_o = mem_q[peek_addr_i];

endmodule

// File: rtl/sample_buffer.sv
// Sample store with per-entry valid bitmap, occupancy count, random reads
// and an engine that streams valid entries in ascending address order.
module sample_buffer
  import sample_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [ADDR_W:0]   count,
  input  logic              stream_start,
  output logic              busy,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_last,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int                CNT_W   = count_w(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_valid_q, rd_hit_q;
  stream_state_e     state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q, s_valid_q, s_last_q, done_q;
  logic [DATA_W-1:0] s_data_q, ram_peek;
  logic [ADDR_W-1:0] s_addr_q;
  logic [DEPTH-1:0]  above_mask;

  sample_buffer_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .peek_addr_i(ptr_q),
    .peek_data_o(ram_peek)
  );

  // Clear lands before a same-cycle write so the written entry stays valid.
  always_comb begin
    valid_d = valid_q;
    if (clear) valid_d = '0;
    if (wr_en) valid_d[wr_addr] = 1'b1;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  assign above_mask = ({DEPTH{1'b1}} << ptr_q) << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      rd_valid_q <= rd_en;
      rd_hit_q   <= rd_en & valid_q[rd_addr];
    end
  end

  // Stream handshake: an entry transfers on a rising edge where s_valid and
  // s_ready are both high; while s_valid is high and s_ready is low, s_valid,
  // s_data, s_addr and s_last hold. clear aborts the pass without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_addr_q  <= '0;
      s_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        s_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (stream_start) begin
              ptr_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (valid_q[ptr_q]) begin
              s_valid_q <= 1'b1;
              s_data_q  <= ram_peek;
              s_addr_q  <= ptr_q;
              s_last_q  <= ~|(valid_q & above_mask);
              state_q   <= ST_OUT;
            end else if (ptr_q == PTR_MAX) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              ptr_q <= ptr_q + ADDR_W'(1);
            end
          end
          ST_OUT: begin
            if (s_ready) begin
              s_valid_q <= 1'b0;
              if (s_last_q || ptr_q == PTR_MAX) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                ptr_q   <= ptr_q + ADDR_W'(1);
                state_q <= ST_SCAN;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_hit    = rd_hit_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign s_valid   = s_valid_q;
  assign s_data    = s_data_q;
  assign s_addr    = s_addr_q;
  assign s_last    = s_last_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sample_buffer.sv
// Bench for sample_buffer: directed scenarios plus randomized write/read/stream
// rounds against a behavioural model of the store; second instance at 12x64.
module tb_sample_buffer;
  import sample_buffer_pkg::*;

  localparam int DW = 8;
  localparam int DEP = 16;
  localparam int AW = 4;
  localparam int EW = AW + DW + 1;
  localparam int WDW = 12;
  localparam int WDEP = 64;
  localparam int WAW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main DUT ----------------
  logic          wr_en, clear, rd_en, stream_start, s_ready;
  logic [AW-1:0] wr_addr, rd_addr, s_addr;
  logic [DW-1:0] wr_data, rd_data, s_data;
  logic          rd_valid, rd_hit, busy, s_valid, s_last, done;
  logic [AW:0]   count;
  logic [1:0]    dbg_state;

  sample_buffer #(.DATA_W(DW), .DEPTH(DEP)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .count(count), .stream_start(stream_start),
    .busy(busy), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_addr(s_addr),
    .s_last(s_last), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- wide DUT ----------------
  logic           w_wr_en, w_clear, w_rd_en, w_stream_start, w_s_ready;
  logic [WAW-1:0] w_wr_addr, w_rd_addr, w_s_addr;
  logic [WDW-1:0] w_wr_data, w_rd_data, w_s_data;
  logic           w_rd_valid, w_rd_hit, w_busy, w_s_valid, w_s_last, w_done;
  logic [WAW:0]   w_count;
  logic [1:0]     w_dbg_state;

  sample_buffer #(.DATA_W(WDW), .DEPTH(WDEP)) u_dut_wide (
    .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .clear(w_clear), .rd_en(w_rd_en), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
    .rd_valid(w_rd_valid), .rd_hit(w_rd_hit), .count(w_count), .stream_start(w_stream_start),
    .busy(w_busy), .s_valid(w_s_valid), .s_ready(w_s_ready), .s_data(w_s_data),
    .s_addr(w_s_addr), .s_last(w_s_last), .done(w_done), .dbg_state(w_dbg_state)
  );

  // ---------------- model and scoreboard ----------------
  logic [DW-1:0]  m_mem [DEP];
  logic [DEP-1:0] m_valid = '0;
  logic [DEP-1:0] m_known = '0;
  logic [DW-1:0]  exp_rd = '0;
  bit             exp_rd_known = 1'b1;
  logic [EW-1:0]  exp_q[$];
  int             n_checks = 0;
  int             n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int m_count();
    return $countones(m_valid);
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rd_data"}, rd_data, 0);
    check({pfx, "_rd_valid"}, rd_valid, 0);
    check({pfx, "_rd_hit"}, rd_hit, 0);
    check({pfx, "_count"}, count, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_s_valid"}, s_valid, 0);
    check({pfx, "_s_data"}, s_data, 0);
    check({pfx, "_s_addr"}, s_addr, 0);
    check({pfx, "_s_last"}, s_last, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_state"}, dbg_state, ST_IDLE);
  endtask

  // One clock of host traffic; model applies clear before write, reads see old state.
  task automatic do_cycle(input bit wr, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                          input bit clr, input bit rd, input logic [AW-1:0] raddr);
    logic e_hit;
    e_hit = 1'b0;
    wr_en = wr; wr_addr = waddr; wr_data = wdata; clear = clr; rd_en = rd; rd_addr = raddr;
    if (rd) begin
      exp_rd = m_mem[raddr];
      exp_rd_known = m_known[raddr];
      e_hit = m_valid[raddr];
    end
    if (clr) m_valid = '0;
    if (wr) begin
      m_mem[waddr] = wdata;
      m_valid[waddr] = 1'b1;
      m_known[waddr] = 1'b1;
    end
    tick();
    wr_en = 1'b0; clear = 1'b0; rd_en = 1'b0;
    check("rd_valid", rd_valid, rd);
    if (rd) check("rd_hit", rd_hit, e_hit);
    if (exp_rd_known) check("rd_data", rd_data, exp_rd);
    check("count", count, m_count());
  endtask

  // Streaming pass; expected entries are the model's valid addresses in order.
  task automatic run_stream(input int ready_pct, output int n_cyc, output bit saw_valid);
    logic [EW-1:0] e, held;
    int last_acc, exp_cyc, nv, top;
    bit pending;
    exp_q.delete();
    top = -1;
    for (int a = 0; a < DEP; a++) begin
      if (m_valid[a]) begin
        exp_q.push_back({AW'(a), m_mem[a], 1'b0});
        top = a;
      end
    end
    nv = exp_q.size();
    if (nv > 0) begin
      e = exp_q.pop_back();
      e[0] = 1'b1;
      exp_q.push_back(e);
    end
    // Each address scanned costs a cycle, each emitted entry one more.
    exp_cyc = (nv == 0) ? DEP : top + 1 + nv;
    last_acc = -1; pending = 1'b0; saw_valid = 1'b0; n_cyc = 0; held = '0;
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    check("stream_busy", busy, 1);
    while (!done && n_cyc < 8 * DEP + 8) begin
      if (pending) check("stream_hold", {s_valid, s_addr, s_data, s_last}, {1'b1, held});
      if (s_valid) saw_valid = 1'b1;
      s_ready = ($urandom_range(99) < ready_pct);
      if (s_valid && s_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("stream_entry", {s_addr, s_data, s_last}, e);
        last_acc = n_cyc;
      end
      pending = s_valid && !s_ready;
      held = {s_addr, s_data, s_last};
      tick();
      n_cyc++;
    end
    s_ready = 1'b0;
    check("stream_done", done, 1);
    check("stream_busy_fall", busy, 0);
    check("stream_left", exp_q.size(), 0);
    if (last_acc >= 0) check("done_latency", n_cyc - last_acc, 1);
    if (ready_pct == 100) check("stream_cycles", n_cyc, exp_cyc);
    tick();
    check("done_pulse", done, 0);
  endtask

  int wa[3] = '{2, 5, 63};
  int wd[3] = '{12'hA11, 12'h5B2, 12'hFC3};

  initial begin
    int n, k;
    bit sv;
    logic [DW-1:0] held_d;
    logic [WAW+WDW:0] we;
    wr_en = 0; wr_addr = '0; wr_data = '0; clear = 0; rd_en = 0; rd_addr = '0;
    stream_start = 0; s_ready = 0;
    w_wr_en = 0; w_wr_addr = '0; w_wr_data = '0; w_clear = 0; w_rd_en = 0; w_rd_addr = '0;
    w_stream_start = 0; w_s_ready = 0;

    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Scenario 1: three entries, full-rate stream.
    do_cycle(1, 4'd2, 8'h11, 0, 0, 4'd0);
    do_cycle(1, 4'd5, 8'h22, 0, 0, 4'd0);
    do_cycle(1, 4'd15, 8'h33, 0, 0, 4'd0);
    check("s1_count", count, 3);
    run_stream(100, n, sv);

    // Scenario 2: read-first on a same-cycle write.
    do_cycle(1, 4'd4, 8'h55, 0, 0, 4'd0);
    do_cycle(1, 4'd4, 8'hAA, 0, 1, 4'd4);
    check("s2_read_first", rd_data, 8'h55);
    do_cycle(0, 4'd0, 8'h00, 0, 1, 4'd4);
    check("s2_read_new", rd_data, 8'hAA);
    check("s2_hit", rd_hit, 1);

    // Scenario 3: clear with write leaves only the written entry.
    do_cycle(1, 4'd9, 8'h7E, 1, 0, 4'd0);
    check("s3_count", count, 1);
    run_stream(100, n, sv);

    // Scenario 4: backpressure on the first entry; snapshot survives a write.
    held_d = m_mem[9];
    s_ready = 1'b0;
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    k = 0;
    while (!s_valid && k < 2 * DEP) begin
      tick();
      k++;
    end
    check("s4_valid", s_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) do_cycle(1, 4'd9, 8'h99, 0, 0, 4'd0);
      else tick();
      check("s4_hold_valid", s_valid, 1);
      check("s4_hold_data", s_data, held_d);
      check("s4_hold_addr", s_addr, 9);
    end
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    check("s4_done", done, 1);
    check("s4_valid_drop", s_valid, 0);

    // Scenario 5: clear while an entry is offered, then an empty pass.
    do_cycle(1, 4'd3, 8'h31, 0, 0, 4'd0);
    do_cycle(1, 4'd12, 8'hC2, 0, 0, 4'd0);
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    k = 0;
    while (!s_valid && k < 2 * DEP) begin
      tick();
      k++;
    end
    check("s5_valid", s_valid, 1);
    clear = 1'b1; s_ready = 1'b1;
    m_valid = '0;
    tick();
    clear = 1'b0; s_ready = 1'b0;
    check("s5_valid_drop", s_valid, 0);
    check("s5_busy", busy, 0);
    check("s5_no_done", done, 0);
    check("s5_count", count, 0);
    check("s5_state", dbg_state, ST_IDLE);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s5_quiet_done", done, 0);
    end
    // done lands DEPTH edges after the start edge: the 17th cycle counting the request.
    run_stream(100, n, sv);
    check("s5_empty_cycles", n, DEP);
    check("s5_empty_no_valid", sv, 0);

    // Scenario 6: asynchronous reset mid-pass; memory kept, bitmap lost.
    do_cycle(1, 4'd1, 8'hB1, 0, 0, 4'd0);
    do_cycle(1, 4'd7, 8'hC7, 0, 0, 4'd0);
    do_cycle(0, 4'd0, 8'h00, 0, 1, 4'd7);
    s_ready = 1'b1;
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    tick(); tick();
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    s_ready = 1'b0;
    m_valid = '0;
    exp_rd = '0;
    exp_rd_known = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    do_cycle(0, 4'd0, 8'h00, 0, 1, 4'd7);
    check("s6_retained", rd_data, 8'hC7);
    check("s6_invalid", rd_hit, 0);

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      int nops;
      nops = $urandom_range(8, 20);
      for (int i = 0; i < nops; i++) begin
        do_cycle($urandom_range(99) < 70, AW'($urandom_range(DEP - 1)), DW'($urandom_range(255)),
                 $urandom_range(99) < 4, $urandom_range(99) < 50, AW'($urandom_range(DEP - 1)));
      end
      run_stream((r % 2 == 0) ? 100 : int'($urandom_range(30, 90)), n, sv);
    end

    // Wide instance: scenario 1 at DATA_W=12, DEPTH=64.
    w_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_wr_addr = WAW'(wa[i]);
      w_wr_data = WDW'(wd[i]);
      tick();
    end
    w_wr_en = 1'b0;
    check("w_count", w_count, 3);
    w_s_ready = 1'b1;
    w_stream_start = 1'b1;
    tick();
    w_stream_start = 1'b0;
    k = 0; n = 0;
    while (!w_done && n < 4 * WDEP) begin
      if (w_s_valid) begin
        we = (k < 3) ? {WAW'(wa[k]), WDW'(wd[k]), k == 2} : 'x;
        check("w_entry", {w_s_addr, w_s_data, w_s_last}, we);
        k++;
      end
      tick();
      n++;
    end
    w_s_ready = 1'b0;
    check("w_done", w_done, 1);
    check("w_entries", k, 3);
    check("w_cycles", n, wa[2] + 1 + 3);
    tick();
    check("w_done_pulse", w_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sample_buffer.md
# sample_buffer

Parametrised sample store for the regression datapath. Host-side logic writes samples by address. The block does two things with them:
- serves random reads through a registered read port;
- streams every valid entry, in ascending address order, to the downstream accumulator over a valid/ready handshake.

It adds per-entry valid tracking, an occupancy count, a clear operation and the streaming engine. It sits between sample loading and the regression accumulator.

## Interface
Parameters:
- DATA_W, 8, sample width in bits
- DEPTH, 16, number of entries (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clear  in  1  invalidate all entries; aborts any stream
- rd_en  in  1  random-read request
- rd_addr  in  ADDR_W  random-read address
- rd_data  out  DATA_W  read data, registered
- rd_valid  out  1  rd_data valid, one-cycle pulse
- rd_hit  out  1  valid bit of the addressed entry, qualified by rd_valid
- count  out  ADDR_W+1  number of valid entries (0..DEPTH)
- stream_start  in  1  start a streaming pass; ignored while busy
- busy  out  1  stream in progress
- s_valid  out  1  stream entry available
- s_ready  in  1  downstream accepts entry
- s_data  out  DATA_W  stream entry data
- s_addr  out  ADDR_W  stream entry address
- s_last  out  1  current entry is the highest-address valid entry
- done  out  1  one-cycle pulse at the end of a pass

## Operation
- Storage: DEPTH×DATA_W array, not reset. Valid bitmap of DEPTH bits, reset to 0.
- Write: wr_en sets mem[wr_addr] ← wr_data and valid[wr_addr] ← 1.
- Clear: clear zeroes the bitmap. If clear and wr_en occur in the same cycle, the clear applies first, so the written entry is left as the only valid entry.
- count: registered popcount of the bitmap as it will stand after the current edge's updates.
- Random read:
  - rd_en at edge t gives rd_data = mem[rd_addr] and rd_hit = valid[rd_addr] at t+1, with rd_valid = 1.
  - Read-first: a same-cycle write to the same address returns the old data and the old valid bit.
  - rd_data holds its value between reads.
- Stream FSM states: IDLE, SCAN, OUT.
  - IDLE: on stream_start, ptr ← 0, go to SCAN. busy = 0.
  - SCAN: examine valid[ptr].
    - If set: load s_data, s_addr and s_last; s_valid ← 1; go to OUT.
    - Else if ptr == DEPTH-1: pulse done, go to IDLE.
    - Else: ptr ← ptr+1.
  - OUT: hold s_valid, s_data, s_addr and s_last until s_valid & s_ready.
    - On acceptance, if s_last or ptr == DEPTH-1: pulse done, go to IDLE.
    - Otherwise: ptr ← ptr+1, go to SCAN.
- s_last is computed at load time as "no valid bit set above ptr".
- Writes during a pass are allowed. Addresses above ptr are seen with their updated valid bits. s_data is a snapshot, so a write to the held address does not alter it.
- clear during a pass: FSM → IDLE, s_valid ← 0, no done pulse. Clear has priority over acceptance in the same cycle.
- Empty buffer: the pass scans all DEPTH addresses, then pulses done with no s_valid.

## Timing
- Reset values: rd_data 0, rd_valid 0, rd_hit 0, count 0, busy 0, s_valid 0, s_data 0, s_addr 0, s_last 0, done 0, FSM IDLE, ptr 0.
- Reset asserted mid-pass: immediate return to reset values. Memory contents are retained but invalid.
- stream_start at edge t: busy = 1 from t+1; first s_valid earliest at t+2.
- Sustained rate: one entry per 2 cycles (SCAN + OUT) with s_ready held high. Each skipped invalid entry costs 1 cycle.
- done is asserted in the cycle after the final acceptance or final scan, together with busy falling.
- count reflects a write or clear 1 cycle after the edge that applied it.

## Structure
- Package sample_buffer_pkg holds the state enum (IDLE, SCAN, OUT) and shared width helpers.
- Sub-module sample_buffer_ram holds the storage array, the write port and the registered read-first read port.
- Top level holds the bitmap, popcount, FSM and output registers.

## Test plan
Defaults DATA_W=8, DEPTH=16 unless noted.
- Reset, then write 0x11@2, 0x22@5, 0x33@15 → count = 3. Stream with s_ready=1 gives (2,0x11), (5,0x22), (15,0x33,s_last); done 1 cycle after the last acceptance.
- Same-cycle write 0xAA@4 and rd_en@4 (old 0x55) → rd_data = 0x55. A following read gives 0xAA with rd_hit = 1.
- clear together with wr_en 0x7E@9 → count = 1. Stream yields only (9,0x7E,s_last).
- s_ready low for 5 cycles on the first entry → s_valid and s_data stable throughout. A write to the held address does not change s_data.
- clear while in OUT → s_valid drops next cycle, busy = 0, no done pulse. A new stream_start on an empty buffer gives done after 17 cycles with no s_valid.
- rst_n asserted asynchronously mid-pass → all outputs 0 immediately. Repeat the first scenario with DATA_W=12, DEPTH=64.
